// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register sitting directly behind the core ALU.
// Registers the execute result and memory-op decode, forms the aligned
// data-memory request (byte enables plus lane-replicated store data) and
// provides a forwarding tap for the execute bypass muxes.
// Optional build macro: EX_MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses raise misalign and are
//                suppressed (no read, no write, no writeback).
//   undefined -> misalign tied 0; halfword uses a[1], word ignores a[1:0].
module ex_mem_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       alu_out,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [2:0]            funct3,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  reg_we,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [XLEN-1:0]       dmem_addr,
  output logic                  dmem_re,
  output logic [3:0]            dmem_we,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [2:0]            mem_funct3,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  fwd_valid,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  misalign
);

  logic                  mem_valid_reg;
  logic [XLEN-1:0]       addr_reg;
  logic [XLEN-1:0]       wdata_reg;
  logic [3:0]            we_reg;
  logic                  re_reg;
  logic [2:0]            funct3_reg;
  logic                  wb_we_reg;
  logic [REG_ADDR_W-1:0] rd_reg;

  logic [1:0]            a;
  logic [3:0]            we_next;
  logic                  re_next;
  logic [XLEN-1:0]       wdata_next;
  logic                  wb_we_next;
  logic                  mis_next;
  logic                  load_en;

  // A new instruction can enter whenever the slot is empty or draining.
  assign ex_ready = ~mem_valid_reg | mem_ready;
  assign load_en  = ex_valid & ex_ready & ~flush;

  // Decode the incoming instruction into the aligned memory request.
  always_comb begin
    a          = alu_out[1:0];
    we_next    = 4'b0000;
    re_next    = 1'b0;
    wdata_next = '0;
    mis_next   = 1'b0;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    if (is_load) begin
      mis_next = (((funct3 == 3'b001) || (funct3 == 3'b101)) && a[0]) ||
                 ((funct3 == 3'b010) && (a != 2'b00));
    end else if (is_store) begin
      mis_next = ((funct3 == 3'b001) && a[0]) ||
                 ((funct3 == 3'b010) && (a != 2'b00));
    end
`endif
    if (is_load) begin
      // Load wins over a simultaneous store flag.
      re_next = 1'b1;
    end else if (is_store) begin
      case (funct3)
        3'b000: begin
          wdata_next = {4{rs2_data[7:0]}};
          we_next    = 4'b0001 << a;
        end
        3'b001: begin
          wdata_next = {2{rs2_data[15:0]}};
          we_next    = 4'b0011 << {a[1], 1'b0};
        end
        3'b010: begin
          wdata_next = rs2_data;
          we_next    = 4'b1111;
        end
        default: begin
          wdata_next = '0;
          we_next    = 4'b0000;
        end
      endcase
    end
    if (mis_next) begin
      re_next = 1'b0;
      we_next = 4'b0000;
    end
    wb_we_next = reg_we & (rd != '0) & ~mis_next;
  end

  // Pipeline register: flush kills, load captures, drain empties, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 4'b0000;
      re_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      wb_we_reg     <= 1'b0;
      rd_reg        <= '0;
    end else if (flush || (ex_ready && !load_en)) begin
      mem_valid_reg <= 1'b0;
      we_reg        <= 4'b0000;
      re_reg        <= 1'b0;
      wb_we_reg     <= 1'b0;
    end else if (load_en) begin
      mem_valid_reg <= 1'b1;
      addr_reg      <= alu_out;
      wdata_reg     <= wdata_next;
      we_reg        <= we_next;
      re_reg        <= re_next;
      funct3_reg    <= funct3;
      wb_we_reg     <= wb_we_next;
      rd_reg        <= rd;
    end
  end

`ifdef EX_MEM_MISALIGN_TRAP_EN
  logic misalign_reg;

  // Misalign flag travels with the instruction and drops with mem_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
    end else if (flush || (ex_ready && !load_en)) begin
      misalign_reg <= 1'b0;
    end else if (load_en) begin
      misalign_reg <= mis_next;
    end
  end

  assign misalign = misalign_reg;
`else
  assign misalign = 1'b0;
`endif

  assign mem_valid  = mem_valid_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_re    = re_reg;
  assign dmem_we    = we_reg;
  assign dmem_wdata = wdata_reg;
  assign mem_funct3 = funct3_reg;
  assign wb_we      = wb_we_reg;
  assign wb_rd      = rd_reg;
  assign fwd_valid  = mem_valid_reg & wb_we_reg & ~re_reg;
  assign fwd_data   = addr_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: store alignment, stall/hold, forwarding,
// flush, load/misalign behaviour and asynchronous reset mid-stall.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        reg_we;
  logic [4:0]  rd;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] dmem_addr;
  logic        dmem_re;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic [2:0]  mem_funct3;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .alu_out    (alu_out),
    .rs2_data   (rs2_data),
    .funct3     (funct3),
    .is_load    (is_load),
    .is_store   (is_store),
    .reg_we     (reg_we),
    .rd         (rd),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .dmem_addr  (dmem_addr),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .mem_funct3 (mem_funct3),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .fwd_valid  (fwd_valid),
    .fwd_data   (fwd_data),
    .misalign   (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] d,
                       input logic [2:0] f3, input logic ld, input logic st,
                       input logic we, input logic [4:0] r);
    ex_valid = v; alu_out = addr; rs2_data = d; funct3 = f3;
    is_load = ld; is_store = st; reg_we = we; rd = r;
  endtask

  task automatic show(input string name);
    $display("txn %-12s valid=%b addr=%h we=%b re=%b wdata=%h wb_we=%b rd=%0d fwd=%b mis=%b",
             name, mem_valid, dmem_addr, dmem_we, dmem_re, dmem_wdata, wb_we, wb_rd,
             fwd_valid, misalign);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    step(); step();
    show("reset");
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_we", dmem_we, 4'b0000);
    chk("rst_re", dmem_re, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_ex_ready", ex_ready, 1'b1);
    rst_n = 1'b1;
    step();
    chk("idle_mem_valid", mem_valid, 1'b0);

    // SB at byte 3
    drive(1'b1, 32'h1000_0003, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
    step(); show("sb");
    chk("sb_valid", mem_valid, 1'b1);
    chk("sb_we", dmem_we, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
    chk("sb_addr", dmem_addr, 32'h1000_0003);
    chk("sb_re", dmem_re, 1'b0);

    // SH at halfword 2
    drive(1'b1, 32'h1000_0002, 32'h0000_1234, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0);
    step(); show("sh");
    chk("sh_we", dmem_we, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_funct3", mem_funct3, 3'b001);

    // SW aligned
    drive(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    step(); show("sw");
    chk("sw_we", dmem_we, 4'b1111);
    chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);

    // Stall: downstream not ready, new ADD presented for 3 cycles
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_0042, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    chk("stall_ex_ready", ex_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); show("stall");
      chk("stall_valid", mem_valid, 1'b1);
      chk("stall_addr", dmem_addr, 32'h1000_0000);
      chk("stall_we", dmem_we, 4'b1111);
      chk("stall_wdata", dmem_wdata, 32'hCAFE_F00D);
    end
    mem_ready = 1'b1;
    #1;
    chk("unstall_ex_ready", ex_ready, 1'b1);
    step(); show("add");
    chk("add_addr", dmem_addr, 32'h0000_0042);
    chk("add_fwd_valid", fwd_valid, 1'b1);
    chk("add_fwd_data", fwd_data, 32'h0000_0042);
    chk("add_wb_rd", wb_rd, 5'd5);
    chk("add_wb_we", wb_we, 1'b1);
    chk("add_we", dmem_we, 4'b0000);
    chk("add_re", dmem_re, 1'b0);

    // Same ADD to x0
    drive(1'b1, 32'h0000_0042, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0);
    step(); show("add_x0");
    chk("x0_wb_we", wb_we, 1'b0);
    chk("x0_fwd_valid", fwd_valid, 1'b0);

    // Bubble drains the stage
    drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    step(); show("bubble");
    chk("bubble_valid", mem_valid, 1'b0);

    // Stalled store killed by flush, incoming instruction discarded
    drive(1'b1, 32'h0000_0020, 32'h1111_2222, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    chk("fl_pre_valid", mem_valid, 1'b1);
    mem_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'h0000_0024, 32'h3333_4444, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    step(); show("flush");
    chk("fl_valid", mem_valid, 1'b0);
    chk("fl_we", dmem_we, 4'b0000);
    flush = 1'b0; mem_ready = 1'b1;
    drive(1'b1, 32'h0000_0024, 32'h3333_4444, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    flush = 1'b1;
    step();
    chk("fl_discard_valid", mem_valid, 1'b0);
    flush = 1'b0;

    // LW at byte offset 1
    drive(1'b1, 32'h1000_0001, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 1'b1, 5'd7);
    step(); show("lw_mis");
    chk("lw_valid", mem_valid, 1'b1);
    chk("lw_we", dmem_we, 4'b0000);
    chk("lw_wdata", dmem_wdata, 32'h0);
    chk("lw_fwd_valid", fwd_valid, 1'b0);
`ifdef EX_MEM_MISALIGN_TRAP_EN
    chk("lw_misalign", misalign, 1'b1);
    chk("lw_re", dmem_re, 1'b0);
    chk("lw_wb_we", wb_we, 1'b0);
`else
    chk("lw_misalign", misalign, 1'b0);
    chk("lw_re", dmem_re, 1'b1);
    chk("lw_wb_we", wb_we, 1'b1);
`endif

    // Load and store flags both set: load wins
    drive(1'b1, 32'h0000_0100, 32'h5555_5555, 3'b010, 1'b1, 1'b1, 1'b1, 5'd3);
    step(); show("ld_st");
    chk("ldst_re", dmem_re, 1'b1);
    chk("ldst_we", dmem_we, 4'b0000);
    chk("ldst_misalign", misalign, 1'b0);

    // SB at byte 1
    drive(1'b1, 32'h0000_0101, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0);
    step(); show("sb1");
    chk("sb1_we", dmem_we, 4'b0010);
    chk("sb1_wdata", dmem_wdata, 32'hA5A5_A5A5);

    // Undefined store funct3 is a no-op write
    drive(1'b1, 32'h0000_0200, 32'h1234_5678, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0);
    step(); show("st_bad");
    chk("stbad_we", dmem_we, 4'b0000);
    chk("stbad_valid", mem_valid, 1'b1);

    // Reset asserted mid-stall takes effect without a clock edge
    drive(1'b1, 32'h0000_0300, 32'h89AB_CDEF, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
    step();
    mem_ready = 1'b0;
    ex_valid = 1'b0;
    step();
    chk("prerst_we", dmem_we, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    show("async_rst");
    chk("arst_valid", mem_valid, 1'b0);
    chk("arst_we", dmem_we, 4'b0000);
    chk("arst_addr", dmem_addr, 32'h0);
    chk("arst_ex_ready", ex_ready, 1'b1);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
